// File: rtl/dmem_arbiter_if.sv
// Shared data-RAM bus: pipeline (P) and debug (D) request channels plus the RAM-side drive.
// The arbiter takes the slave view; requesters and the RAM model take the master view.
interface dmem_arbiter_if #(
    parameter int unsigned AW = 15,
    parameter int unsigned DW = 16
);
    logic          p_req;
    logic          p_we;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata;
    logic          p_gnt;
    logic          p_rvalid;
    logic [DW-1:0] p_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic          ram_wen;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_win;
    logic [DW-1:0] ram_rout;

    modport slave (
        input  p_req, p_we, p_addr, p_wdata,
        output p_gnt, p_rvalid, p_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output ram_wen, ram_addr, ram_win,
        input  ram_rout
    );

    modport master (
        output p_req, p_we, p_addr, p_wdata,
        input  p_gnt, p_rvalid, p_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  ram_wen, ram_addr, ram_win,
        output ram_rout
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-RAM arbiter: pipeline has priority, debug gets a forced grant after
// MAXWAIT consecutive denied cycles. Read data returns one cycle after the grant.
module dmem_arbiter #(
    parameter int unsigned AW      = 15,
    parameter int unsigned DW      = 16,
    parameter int unsigned MAXWAIT = 4
) (
    input  logic           clock,
    input  logic           resetn,
    dmem_arbiter_if.slave  io_bus
);
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] MaxWait = CW'(MAXWAIT);

    localparam logic [1:0] RdNone = 2'd0;
    localparam logic [1:0] RdP    = 2'd1;
    localparam logic [1:0] RdD    = 2'd2;

    logic [CW-1:0] r_wait_cnt;
    logic [CW-1:0] w_wait_cnt_d;
    logic [1:0]    r_rd_owner;
    logic [1:0]    w_rd_owner_d;

    logic          w_force_d;
    logic          w_d_gnt;
    logic          w_p_gnt;
    logic          w_ram_wen;
    logic [AW-1:0] w_ram_addr;
    logic [DW-1:0] w_ram_win;

    // Grant: D only when P is idle or D has waited long enough.
    assign w_force_d = (r_wait_cnt == MaxWait);
    assign w_d_gnt   = io_bus.d_req & (w_force_d | ~io_bus.p_req);
    assign w_p_gnt   = io_bus.p_req & ~w_d_gnt;

    always_comb begin
        w_ram_wen  = 1'b0;
        w_ram_addr = '0;
        w_ram_win  = '0;
        if (w_d_gnt) begin
            w_ram_wen  = io_bus.d_we;
            w_ram_addr = io_bus.d_addr;
            w_ram_win  = io_bus.d_wdata;
        end else if (w_p_gnt) begin
            w_ram_wen  = io_bus.p_we;
            w_ram_addr = io_bus.p_addr;
            w_ram_win  = io_bus.p_wdata;
        end
    end

    // Counts consecutive denied D cycles; any gap or grant restarts it.
    always_comb begin
        w_wait_cnt_d = '0;
        if (io_bus.d_req && !w_d_gnt) begin
            w_wait_cnt_d = (r_wait_cnt == MaxWait) ? MaxWait : r_wait_cnt + 1'b1;
        end
    end

    always_comb begin
        w_rd_owner_d = RdNone;
        if (w_d_gnt && !io_bus.d_we) begin
            w_rd_owner_d = RdD;
        end else if (w_p_gnt && !io_bus.p_we) begin
            w_rd_owner_d = RdP;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wait_cnt <= '0;
            r_rd_owner <= RdNone;
        end else begin
            r_wait_cnt <= w_wait_cnt_d;
            r_rd_owner <= w_rd_owner_d;
        end
    end

    assign io_bus.d_gnt    = w_d_gnt;
    assign io_bus.p_gnt    = w_p_gnt;
    assign io_bus.ram_wen  = w_ram_wen;
    assign io_bus.ram_addr = w_ram_addr;
    assign io_bus.ram_win  = w_ram_win;

    assign io_bus.p_rvalid = (r_rd_owner == RdP);
    assign io_bus.d_rvalid = (r_rd_owner == RdD);
    assign io_bus.p_rdata  = io_bus.ram_rout;
    assign io_bus.d_rdata  = io_bus.ram_rout;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a write-first synchronous RAM model.
// Inputs change on the falling edge; outputs are checked before the next rising edge.
module tb_dmem_arbiter;
    localparam int unsigned AW = 15;
    localparam int unsigned DW = 16;

    logic clock;
    logic resetn;
    int   n_tot;
    int   n_bad;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dmem_arbiter #(.AW(AW), .DW(DW), .MAXWAIT(4)) dut (
        .clock  (clock),
        .resetn (resetn),
        .io_bus (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Write-first synchronous RAM.
    always @(posedge clock) begin
        if (bus.ram_wen) begin
            mem[bus.ram_addr] <= bus.ram_win;
            bus.ram_rout      <= bus.ram_win;
        end else begin
            bus.ram_rout <= mem[bus.ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_reqs();
        bus.p_req = 1'b0; bus.p_we = 1'b0; bus.p_addr = '0; bus.p_wdata = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    endtask

    initial begin
        n_tot = 0;
        n_bad = 0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[15'h0010] = 16'hBEEF;
        mem[15'h0001] = 16'h1111;
        mem[15'h0002] = 16'h2222;
        mem[15'h0003] = 16'h3333;
        bus.ram_rout = '0;
        idle_reqs();
        resetn = 1'b0;

        // Reset state
        #12;
        chk("rst_p_rvalid", 32'(bus.p_rvalid), 32'd0);
        chk("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        chk("rst_gnts", {30'd0, bus.p_gnt, bus.d_gnt}, 32'd0);
        chk("rst_ram_wen", 32'(bus.ram_wen), 32'd0);
        chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        @(negedge clock);
        resetn = 1'b1;

        // P load only
        @(negedge clock);
        bus.p_req = 1'b1; bus.p_we = 1'b0; bus.p_addr = 15'h0010;
        #1;
        chk("pld_p_gnt", 32'(bus.p_gnt), 32'd1);
        chk("pld_d_gnt", 32'(bus.d_gnt), 32'd0);
        chk("pld_ram_addr", 32'(bus.ram_addr), 32'h10);
        chk("pld_ram_wen", 32'(bus.ram_wen), 32'd0);
        @(negedge clock);
        chk("pld_p_rvalid", 32'(bus.p_rvalid), 32'd1);
        chk("pld_p_rdata", 32'(bus.p_rdata), 32'hBEEF);
        chk("pld_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        idle_reqs();

        // D write, then P read of the same word
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 15'h0020; bus.d_wdata = 16'h1234;
        #1;
        chk("dwr_d_gnt", 32'(bus.d_gnt), 32'd1);
        chk("dwr_p_gnt", 32'(bus.p_gnt), 32'd0);
        chk("dwr_ram_wen", 32'(bus.ram_wen), 32'd1);
        chk("dwr_ram_addr", 32'(bus.ram_addr), 32'h20);
        chk("dwr_ram_win", 32'(bus.ram_win), 32'h1234);
        @(negedge clock);
        chk("dwr_no_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        idle_reqs();
        bus.p_req = 1'b1; bus.p_we = 1'b0; bus.p_addr = 15'h0020;
        #1;
        chk("raw_p_gnt", 32'(bus.p_gnt), 32'd1);
        @(negedge clock);
        chk("raw_p_rvalid", 32'(bus.p_rvalid), 32'd1);
        chk("raw_p_rdata", 32'(bus.p_rdata), 32'h1234);
        idle_reqs();

        // Contention: P wins 4 cycles, then D is forced through
        @(negedge clock);
        bus.p_req = 1'b1; bus.p_we = 1'b0; bus.p_addr = 15'h0001;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 15'h0010;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk($sformatf("cont_p_gnt_%0d", i), 32'(bus.p_gnt), 32'd1);
            chk($sformatf("cont_d_gnt_%0d", i), 32'(bus.d_gnt), 32'd0);
            @(negedge clock);
        end
        #1;
        chk("cont_forced_d_gnt", 32'(bus.d_gnt), 32'd1);
        chk("cont_forced_p_gnt", 32'(bus.p_gnt), 32'd0);
        chk("cont_forced_addr", 32'(bus.ram_addr), 32'h10);
        chk("cont_p_rvalid_prev", 32'(bus.p_rvalid), 32'd1);
        @(negedge clock);
        bus.d_req = 1'b0;
        #1;
        chk("cont_d_rvalid", 32'(bus.d_rvalid), 32'd1);
        chk("cont_d_rdata", 32'(bus.d_rdata), 32'hBEEF);
        chk("cont_p_rvalid_gap", 32'(bus.p_rvalid), 32'd0);
        chk("cont_p_gnt_after", 32'(bus.p_gnt), 32'd1);
        @(negedge clock);
        chk("cont_p_rvalid_after", 32'(bus.p_rvalid), 32'd1);
        chk("cont_p_rdata_after", 32'(bus.p_rdata), 32'h1111);
        idle_reqs();
        @(negedge clock);

        // Back-to-back P loads
        bus.p_req = 1'b1; bus.p_we = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            bus.p_addr = 15'(i);
            #1;
            chk($sformatf("b2b_p_gnt_%0d", i), 32'(bus.p_gnt), 32'd1);
            @(negedge clock);
            chk($sformatf("b2b_p_rvalid_%0d", i), 32'(bus.p_rvalid), 32'd1);
            chk($sformatf("b2b_p_rdata_%0d", i), 32'(bus.p_rdata), 32'h1111 * i);
        end
        idle_reqs();
        @(negedge clock);
        chk("b2b_p_rvalid_end", 32'(bus.p_rvalid), 32'd0);

        // D withdrawn after 2 denied cycles: counter must restart from zero
        bus.p_req = 1'b1; bus.p_we = 1'b0; bus.p_addr = 15'h0001;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 15'h0002;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("wd_d_gnt_%0d", i), 32'(bus.d_gnt), 32'd0);
            @(negedge clock);
        end
        bus.d_req = 1'b0;
        #1;
        chk("wd_dropped_d_gnt", 32'(bus.d_gnt), 32'd0);
        @(negedge clock);
        chk("wd_no_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        bus.d_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("wd_rewait_d_gnt_%0d", i), 32'(bus.d_gnt), 32'd0);
            @(negedge clock);
        end
        #1;
        chk("wd_rewait_forced", 32'(bus.d_gnt), 32'd1);
        @(negedge clock);
        idle_reqs();
        #1;
        chk("wd_d_rvalid", 32'(bus.d_rvalid), 32'd1);
        chk("wd_d_rdata", 32'(bus.d_rdata), 32'h2222);
        @(negedge clock);

        // Async reset right after a granted load cancels the pending rvalid
        bus.p_req = 1'b1; bus.p_we = 1'b0; bus.p_addr = 15'h0010;
        #1;
        chk("ar_p_gnt", 32'(bus.p_gnt), 32'd1);
        @(negedge clock);
        idle_reqs();
        #1;
        chk("ar_p_rvalid_pre", 32'(bus.p_rvalid), 32'd1);
        resetn = 1'b0;
        #1;
        chk("ar_p_rvalid_cut", 32'(bus.p_rvalid), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        bus.p_req = 1'b1; bus.p_we = 1'b0; bus.p_addr = 15'h0003;
        #1;
        chk("ar_post_p_gnt", 32'(bus.p_gnt), 32'd1);
        @(negedge clock);
        idle_reqs();
        chk("ar_post_p_rvalid", 32'(bus.p_rvalid), 32'd1);
        chk("ar_post_p_rdata", 32'(bus.p_rdata), 32'h3333);
        @(negedge clock);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data RAM between two requesters, one access per cycle.
- Requester P is the pipeline MEM stage (loads/stores); requester D is the debug/loader port that preloads or inspects data memory.
- P has default priority. A starvation counter forces a D grant after MAXWAIT consecutive denied cycles.
- Drives the RAM write-enable, address and write data, and returns read data with a one-cycle valid strobe to whichever requester issued the read.

Parameters:
- AW, 15, RAM word-address width (byte address >> 1 is done by the requester).
- DW, 16, data width.
- MAXWAIT, 4, consecutive denied D-request cycles before D is forced to priority (1..15).

Ports:
- clock  input  1  system clock, rising edge
- resetn  input  1  reset; asynchronous, active-low
- p_req  input  1  pipeline access request, held until granted
- p_we  input  1  1 = store, 0 = load
- p_addr  input  AW  pipeline word address
- p_wdata  input  DW  pipeline store data
- p_gnt  output  1  pipeline access accepted this cycle (combinational); low while p_req high = stall
- p_rvalid  output  1  pipeline load data valid (cycle after a granted load)
- p_rdata  output  DW  pipeline load data
- d_req  input  1  debug access request, held until granted
- d_we  input  1  1 = write, 0 = read
- d_addr  input  AW  debug word address
- d_wdata  input  DW  debug write data
- d_gnt  output  1  debug access accepted this cycle (combinational)
- d_rvalid  output  1  debug read data valid
- d_rdata  output  DW  debug read data
- ram_wen  output  1  RAM write enable
- ram_addr  output  AW  RAM address (shared read/write)
- ram_win  output  DW  RAM write data
- ram_rout  input  DW  RAM read data, valid the cycle after the address is presented (synchronous read)

Behaviour:
- Reset (async, resetn low): wait_cnt = 0; rd_owner = NONE; p_rvalid = d_rvalid = 0.
- Combinational outputs during reset follow the grant logic below.
- force_d = (wait_cnt == MAXWAIT).
- Grant, same cycle:
  - d_gnt = d_req & (force_d | ~p_req).
  - p_gnt = p_req & ~d_gnt.
  - At most one grant is high in any cycle.
- RAM drive:
  - If d_gnt: ram_addr = d_addr, ram_win = d_wdata, ram_wen = d_we.
  - Else if p_gnt: ram_addr = p_addr, ram_win = p_wdata, ram_wen = p_we.
  - Else: ram_addr = 0, ram_win = 0, ram_wen = 0.
- Starvation counter, per clock:
  - if d_req & ~d_gnt: wait_cnt + 1, saturating at MAXWAIT;
  - else: 0.
  - Counter returns to 0 the cycle after a D grant.
- Read return:
  - rd_owner register holds D if d_gnt & ~d_we, P if p_gnt & ~p_we, else NONE.
  - p_rvalid = (rd_owner == P); d_rvalid = (rd_owner == D).
  - p_rdata = d_rdata = ram_rout, always driven; consumers qualify with rvalid.
- Latency: write completes at the grant edge. Read data arrives one cycle after the grant, with no bubble. Back-to-back grants give one access per cycle.
- Read-after-write to the same address on consecutive cycles returns the new data (RAM write-first ordering at the edge).
- Simultaneous P and D requests with wait_cnt < MAXWAIT: P wins, D waits, counter increments.
- Request dropped before grant: legal. Counter clears and no access occurs.
- Reset mid-operation: a pending rvalid is cancelled (outputs 0). No RAM write occurs while resetn is low only if no request is present; requesters must hold req low during reset.

Test Plan:
- P load only: p_req=1, p_we=0, p_addr=0x0010, RAM[0x10]=0xBEEF -> p_gnt=1 same cycle; next cycle p_rvalid=1, p_rdata=0xBEEF, d_rvalid=0.
- D write then P read: d_req write 0x0020 <- 0x1234 (p_req=0) -> d_gnt=1, ram_wen=1; next cycle P load 0x0020 -> p_rdata=0x1234 with p_rvalid.
- Contention, MAXWAIT=4: p_req and d_req held high, both reads -> p_gnt for 4 cycles (wait_cnt 1..4); cycle 5 d_gnt=1, p_gnt=0; cycle 6 p_gnt=1 and d_rvalid=1.
- Back-to-back P loads to 0x1, 0x2, 0x3 -> p_gnt each cycle; p_rvalid high 3 consecutive cycles with data in order.
- D request withdrawn: d_req high 2 denied cycles then low -> wait_cnt back to 0; no D access, no d_rvalid.
- Async reset asserted the cycle after a granted load -> p_rvalid drops to 0 immediately; after release, wait_cnt=0 and a P request is granted normally.
